// File: rtl/csa_resolve.sv
// Resolves a carry-save pair (sum, unshifted carry) into binary, CHUNK bits per cycle.
// Optional overflow output io_out_ovf is built only when CSA_RESOLVE_OVF_EN is defined.
//
// state | meaning
// IDLE  | ready for an operand pair
// BUSY  | resolving chunk k with the ripple carry held in carry
// DONE  | result presented, waiting for io_out_ready
module csa_resolve #(
    parameter int WIDTH = 13,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_0,
    input  logic [WIDTH-1:0] io_in_1,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic             io_out_ovf
`endif
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int TOPW   = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   op_a;
    logic [PW-1:0]   op_b;
    logic [PW-1:0]   res;
    logic [KW-1:0]   k;
    logic            carry;

    logic [WIDTH-1:0] in1_shifted;
    int               sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             carry_out;
    logic [PW-1:0]    res_next;

`ifdef CSA_RESOLVE_OVF_EN
    logic b_msb;
    logic ovf_r;
    assign io_out_ovf = ovf_r;
`endif

    assign in1_shifted  = io_in_1 << 1;
    assign io_in_ready  = (state == IDLE);
    assign io_out_valid = (state == DONE);
    assign io_out_bits  = res[WIDTH-1:0];

    // Operands are zero-padded to PW bits, so in the short top chunk the true
    // carry-out of bit WIDTH-1 lands at chunk_sum[TOPW].
    always_comb begin
        sh        = int'(k) * CHUNK;
        a_chunk   = CHUNK'(op_a >> sh);
        b_chunk   = CHUNK'(op_b >> sh);
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry);
        carry_out = (k == K_LAST) ? chunk_sum[TOPW] : chunk_sum[CHUNK];
        res_next  = (res & ~(PW'({CHUNK{1'b1}}) << sh))
                  | (PW'(chunk_sum[CHUNK-1:0]) << sh);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            k     <= '0;
            carry <= 1'b0;
`ifdef CSA_RESOLVE_OVF_EN
            b_msb <= 1'b0;
            ovf_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        op_a  <= PW'(io_in_0);
                        op_b  <= PW'(in1_shifted);
                        res   <= '0;
                        k     <= '0;
                        carry <= 1'b0;
`ifdef CSA_RESOLVE_OVF_EN
                        b_msb <= io_in_1[WIDTH-1];
                        ovf_r <= 1'b0;
`endif
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res   <= res_next;
                    carry <= carry_out;
                    k     <= k + KW'(1);
                    if (k == K_LAST) begin
`ifdef CSA_RESOLVE_OVF_EN
                        ovf_r <= carry_out | b_msb;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolve.sv
// Bench for csa_resolve: directed steps plus randomized operand pairs against an
// arithmetic reference (a + 2*b) computed in wide integers.
module tb_csa_resolve;

    localparam int WIDTH  = 13;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_0 = '0;
    logic [WIDTH-1:0] io_in_1 = '0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [WIDTH-1:0] io_out_bits;
`ifdef CSA_RESOLVE_OVF_EN
    logic             io_out_ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               acc;
    } item_t;

    item_t q[$];

    csa_resolve #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_0      (io_in_0),
        .io_in_1      (io_in_1),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .io_out_ovf   (io_out_ovf)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint unsigned s;
        s = longint'(a) + 2 * longint'(b);
        return WIDTH'(s % (64'd1 << WIDTH));
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint unsigned s;
        s = longint'(a) + 2 * longint'(b);
        return (s >= (64'd1 << WIDTH));
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef CSA_RESOLVE_OVF_EN
        check(tag, 32'(io_out_ovf), 32'(exp));
`endif
    endtask

    // One operand pair: accept, wait for the result, stall, then hand it off.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int stall, input bit noisy, input string tag);
        int lat;
        logic [WIDTH-1:0] exp;
        exp = ref_sum(a, b);
        check({tag, "_in_ready"}, 32'(io_in_ready), 32'd1);
        io_in_valid = 1'b1;
        io_in_0     = a;
        io_in_1     = b;
        step();
        if (!noisy) io_in_valid = 1'b0;
        lat = 0;
        while (!io_out_valid && lat < 20) begin
            if (noisy) begin
                io_in_0 = WIDTH'($urandom);
                io_in_1 = WIDTH'($urandom);
            end
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NCHUNK));
        check({tag, "_bits"}, 32'(io_out_bits), 32'(exp));
        check_ovf({tag, "_ovf"}, ref_ovf(a, b));
        for (int i = 0; i < stall; i++) begin
            if (noisy) begin
                io_in_0 = WIDTH'($urandom);
                io_in_1 = WIDTH'($urandom);
            end
            step();
            check({tag, "_stall_bits"}, 32'(io_out_bits), 32'(exp));
            check({tag, "_stall_in_ready"}, 32'(io_in_ready), 32'd0);
            check({tag, "_stall_out_valid"}, 32'(io_out_valid), 32'd1);
        end
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        io_in_valid  = 1'b0;
        check({tag, "_post_out_valid"}, 32'(io_out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(io_in_ready), 32'd1);
    endtask

    initial begin
        item_t it;
        int got;
        int last_acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        reset = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(io_in_ready), 32'd1);
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_bits", 32'(io_out_bits), 32'd0);
        check_ovf("rst_ovf", 1'b0);
        reset = 1'b0;
        step();
        check("idle_hold", 32'(io_in_ready), 32'd1);

        run_op(13'h0FFF, 13'h0001, 0, 1'b0, "carry_ripple");
        run_op(13'h1FFF, 13'h1FFF, 0, 1'b0, "all_ones");
        run_op(WIDTH'($urandom), WIDTH'($urandom), 5, 1'b0, "stall5");
        run_op(WIDTH'($urandom), WIDTH'($urandom), 2, 1'b1, "noisy_in");

        // Abort in the second BUSY cycle; chunk 0 is already non-zero by then.
        io_in_valid = 1'b1;
        io_in_0     = 13'h1FFF;
        io_in_1     = 13'h0000;
        step();
        io_in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_in_ready", 32'(io_in_ready), 32'd1);
        check("abort_out_valid", 32'(io_out_valid), 32'd0);
        check("abort_bits", 32'(io_out_bits), 32'd0);
        check_ovf("abort_ovf", 1'b0);
        run_op(13'h0001, 13'h0000, 0, 1'b0, "after_abort");

        for (int n = 0; n < 8; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), n[0], "rand");
        end

        // Back-to-back with the consumer always ready.
        io_out_ready = 1'b1;
        io_in_valid  = 1'b1;
        got          = 0;
        last_acc     = -1;
        for (int c = 0; c < 200 && got < 6; c++) begin
            if (io_out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_spurious", 32'(io_out_valid), 32'd0);
                end else begin
                    it = q.pop_front();
                    check("b2b_bits", 32'(io_out_bits), 32'(ref_sum(it.a, it.b)));
                    check_ovf("b2b_ovf", ref_ovf(it.a, it.b));
                    check("b2b_latency", 32'(cyc - it.acc), 32'(NCHUNK));
                    got++;
                end
            end
            if (io_in_ready) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                io_in_0 = a;
                io_in_1 = b;
                it.a   = a;
                it.b   = b;
                it.acc = cyc + 1;
                q.push_back(it);
                if (last_acc >= 0) check("b2b_period", 32'(cyc + 1 - last_acc), 32'(NCHUNK + 2));
                last_acc = cyc + 1;
            end else begin
                io_in_0 = WIDTH'($urandom);
                io_in_1 = WIDTH'($urandom);
            end
            step();
        end
        check("b2b_count", 32'(got), 32'd6);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
